hamming_tx_scheduler: RTL and testbench
=======================================

HAMMING_TX_SCHEDULER -- requirements
Module: hamming_tx_scheduler

Interface
REQ-001 The block SHALL have parameter ENC_TIMEOUT, default 4, meaning the maximum number of cycles to wait for enc_valid after an encode request (legal range 2..15).
REQ-002 The block SHALL have port clk, input, 1, the clock (rising edge).
REQ-003 The block SHALL have port rst_n, input, 1, the asynchronous active-low reset.
REQ-004 The block SHALL have ports req0_valid/req1_valid, input, 1 each, requester byte valid.
REQ-005 The block SHALL have ports req0_data/req1_data, input, 8 each, requester byte.
REQ-006 The block SHALL have ports req0_ready/req1_ready, output, 1 each, byte-accept pulse.
REQ-007 The block SHALL have port enc_ena, output, 1, encoder enable.
REQ-008 The block SHALL have port enc_data, output, 4, encoder nibble.
REQ-009 The block SHALL have port enc_code, input, 7, encoder codeword.
REQ-010 The block SHALL have port enc_valid, input, 1, encoder output valid.
REQ-011 The block SHALL have port out_code, output, 7, codeword to the serializer.
REQ-012 The block SHALL have port out_src, output, 1, source requester of out_code.
REQ-013 The block SHALL have port out_half, output, 1, nibble select: 0 = low nibble, 1 = high nibble.
REQ-014 The block SHALL have ports out_valid (output, 1) and out_ready (input, 1), the downstream handshake.
REQ-015 The block SHALL have port err, output, 1, a one-cycle encoder-timeout pulse.

Function
REQ-016 The FSM SHALL have the states IDLE, ENC_LO, WAIT_LO, SEND_LO, ENC_HI, WAIT_HI and SEND_HI.
REQ-017 In IDLE with any reqN_valid high, the block SHALL grant one requester by round-robin, latch its byte and src, pulse that reqN_ready for that one cycle, and go to ENC_LO.
REQ-018 Round-robin priority SHALL start at requester 0 after reset and SHALL pass to the other requester after each grant, so simultaneous requests alternate 0,1,0,1.
REQ-019 reqN_ready SHALL be high only in IDLE and only for the granted requester, and never both high together.
REQ-020 In ENC_LO the block SHALL drive enc_ena=1 and enc_data=byte[3:0] for exactly one cycle, then go to WAIT_LO.
REQ-021 In ENC_HI the block SHALL drive enc_ena=1 and enc_data=byte[7:4] for exactly one cycle, then go to WAIT_HI.
REQ-022 enc_ena SHALL be 0 in all other states; enc_data SHALL be held at the last driven value when not enabled.
REQ-023 In WAIT_x, when enc_valid=1, the block SHALL register enc_code into out_code, set out_half (0 for LO, 1 for HI), and go to SEND_x.
REQ-024 The WAIT_x cycle counter SHALL clear on entry to WAIT_x.
REQ-025 If enc_valid is not seen within ENC_TIMEOUT cycles in WAIT_x, the block SHALL pulse err for one cycle, drop the byte (no further output for it), and return to IDLE.
REQ-026 In SEND_x, out_valid SHALL be 1, and out_code, out_src and out_half SHALL be stable until out_ready=1 is sampled.
REQ-027 When out_ready=1 is sampled in SEND_LO the block SHALL go to ENC_HI; in SEND_HI it SHALL go to IDLE.
REQ-028 out_valid SHALL be 0 in all states other than SEND_x.
REQ-029 out_ready=1 while out_valid=0 SHALL be ignored.
REQ-030 enc_valid outside WAIT_x SHALL be ignored.
REQ-031 Minimum latency SHALL be: accept at cycle 0, enc_ena at cycle 1, enc_valid seen at cycle 2, out_valid from cycle 3.
REQ-032 With out_ready held at 1, one byte SHALL complete every 7 cycles (6 cycles for the byte plus 1 IDLE cycle).
REQ-033 A requester dropping reqN_valid while not granted SHALL cause no state change.

Reset
REQ-034 On rst_n low, asynchronously: state=IDLE, priority=requester 0, counter=0, and all outputs 0 (req0_ready, req1_ready, enc_ena, enc_data=0, out_code=0, out_src=0, out_half=0, out_valid=0, err=0).
REQ-035 Reset mid-transfer SHALL discard the in-flight byte; after reset release the block SHALL resume from IDLE with no spurious out_valid.

Verification
REQ-036 Scenario: real encoder attached, req0 sends 0xA5, out_ready=1 -> out_code 0x5A (src 0, half 0), then 0x25 (src 0, half 1); first out_valid 3 cycles after the accept.
REQ-037 Scenario: req0 and req1 both valid continuously (0x11 and 0x22) -> grants alternate 0,1,0,1 and a byte's two halves are never interleaved with the other source's.
REQ-038 Scenario: out_ready held 0 for 10 cycles in SEND_LO -> out_valid and out_code stay stable for all 10 cycles, with no enc_ena pulses.
REQ-039 Scenario: enc_valid tied to 0 with ENC_TIMEOUT=4 -> err pulses once, 4 cycles after entry to WAIT_LO, then state returns to IDLE and the next request is accepted.
REQ-040 Scenario: rst_n asserted in SEND_HI -> all outputs 0 immediately, and after release the next byte is granted to requester 0.

Source files
------------

// File: rtl/hamming_tx_scheduler.sv
// Hamming(7,4) transmit scheduler: grants bytes from two requesters round-robin and
// pushes each byte through an external encoder as low then high nibble to a serializer.
module hamming_tx_scheduler #(
  parameter int unsigned ENC_TIMEOUT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic       enc_ena,
  output logic [3:0] enc_data,
  input  logic [6:0] enc_code,
  input  logic       enc_valid,
  output logic [6:0] out_code,
  output logic       out_src,
  output logic       out_half,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       err
);

  typedef enum logic [2:0] {
    IDLE, ENC_LO, WAIT_LO, SEND_LO, ENC_HI, WAIT_HI, SEND_HI
  } state_e;

  localparam logic [3:0] CNT_LAST = 4'(ENC_TIMEOUT - 1);

  state_e     state_q, state_d;
  logic       pri_q, pri_d;
  logic [7:0] byte_q, byte_d;
  logic       src_q, src_d;
  logic [3:0] cnt_q, cnt_d;
  logic       enc_ena_q, enc_ena_d;
  logic [3:0] enc_data_q, enc_data_d;
  logic [6:0] out_code_q, out_code_d;
  logic       out_half_q, out_half_d;
  logic       out_valid_q, out_valid_d;
  logic       err_q, err_d;
  logic       grant, gnt_src;

  always_comb begin
    state_d     = state_q;
    pri_d       = pri_q;
    byte_d      = byte_q;
    src_d       = src_q;
    cnt_d       = cnt_q;
    enc_ena_d   = 1'b0;
    enc_data_d  = enc_data_q;
    out_code_d  = out_code_q;
    out_half_d  = out_half_q;
    out_valid_d = out_valid_q;
    err_d       = 1'b0;
    grant       = 1'b0;
    gnt_src     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          // Priority only matters on a tie; the winner hands priority to the other side.
          gnt_src    = (req0_valid && req1_valid) ? pri_q : req1_valid;
          grant      = 1'b1;
          byte_d     = gnt_src ? req1_data : req0_data;
          src_d      = gnt_src;
          pri_d      = ~gnt_src;
          enc_ena_d  = 1'b1;
          enc_data_d = gnt_src ? req1_data[3:0] : req0_data[3:0];
          state_d    = ENC_LO;
        end
      end
      ENC_LO, ENC_HI: begin
        cnt_d   = '0;
        state_d = (state_q == ENC_LO) ? WAIT_LO : WAIT_HI;
      end
      WAIT_LO, WAIT_HI: begin
        if (enc_valid) begin
          out_code_d  = enc_code;
          out_half_d  = (state_q == WAIT_HI);
          out_valid_d = 1'b1;
          state_d     = (state_q == WAIT_LO) ? SEND_LO : SEND_HI;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      SEND_LO: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          enc_ena_d   = 1'b1;
          enc_data_d  = byte_q[7:4];
          state_d     = ENC_HI;
        end
      end
      SEND_HI: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pri_q       <= 1'b0;
      byte_q      <= '0;
      src_q       <= 1'b0;
      cnt_q       <= '0;
      enc_ena_q   <= 1'b0;
      enc_data_q  <= '0;
      out_code_q  <= '0;
      out_half_q  <= 1'b0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pri_q       <= pri_d;
      byte_q      <= byte_d;
      src_q       <= src_d;
      cnt_q       <= cnt_d;
      enc_ena_q   <= enc_ena_d;
      enc_data_q  <= enc_data_d;
      out_code_q  <= out_code_d;
      out_half_q  <= out_half_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
    end
  end

  // Accept pulses are same-cycle with the grant decision; held low while in reset.
  assign req0_ready = rst_n && grant && !gnt_src;
  assign req1_ready = rst_n && grant && gnt_src;
  assign enc_ena    = enc_ena_q;
  assign enc_data   = enc_data_q;
  assign out_code   = out_code_q;
  assign out_src    = src_q;
  assign out_half   = out_half_q;
  assign out_valid  = out_valid_q;
  assign err        = err_q;

endmodule

// File: tb/tb_hamming_tx_scheduler.sv
// Randomized bench for hamming_tx_scheduler: an event-timestamp reference model plus an
// attached behavioural Hamming(7,4) encoder with variable response latency.
module tb_hamming_tx_scheduler;
  localparam int unsigned T    = 4;
  localparam int          NCYC = 1300;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0_valid, req1_valid, req0_ready, req1_ready;
  logic [7:0] req0_data, req1_data;
  logic       enc_ena, enc_valid, out_src, out_half, out_valid, out_ready, err;
  logic [3:0] enc_data;
  logic [6:0] enc_code, out_code;

  hamming_tx_scheduler #(.ENC_TIMEOUT(T)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .enc_ena(enc_ena), .enc_data(enc_data), .enc_code(enc_code), .enc_valid(enc_valid),
    .out_code(out_code), .out_src(out_src), .out_half(out_half),
    .out_valid(out_valid), .out_ready(out_ready), .err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Codeword positions 1..7, MSB first: parity at 1,2,4, data d0..d3 at 3,5,6,7.
  function automatic logic [6:0] ham(input logic [3:0] nib);
    logic [7:1] w;
    int unsigned k;
    w = '0;
    k = 0;
    for (int unsigned p = 1; p <= 7; p++)
      if ((p & (p - 1)) != 0) begin
        w[p] = nib[k];
        k++;
      end
    for (int unsigned b = 1; b <= 4; b = b << 1)
      for (int unsigned p = 1; p <= 7; p++)
        if ((p & b) != 0 && p != b) w[b] = w[b] ^ w[p];
    return {w[1], w[2], w[3], w[4], w[5], w[6], w[7]};
  endfunction

  task automatic check_zero(input string tag);
    check({tag, "_req0_ready"}, req0_ready, 0);
    check({tag, "_req1_ready"}, req1_ready, 0);
    check({tag, "_enc_ena"},    enc_ena,    0);
    check({tag, "_enc_data"},   enc_data,   0);
    check({tag, "_out_code"},   out_code,   0);
    check({tag, "_out_src"},    out_src,    0);
    check({tag, "_out_half"},   out_half,   0);
    check({tag, "_out_valid"},  out_valid,  0);
    check({tag, "_err"},        err,        0);
  endtask

  // Reference model state: abstract flags and absolute cycle stamps of expected events.
  bit         idle, send, half, late, pri, want_reset, force_both;
  bit         cur_src;
  logic [7:0] cur_byte;
  logic [3:0] last_nib;
  logic [6:0] exp_code, pend_code;
  int         enc_due, valid_due, err_due, stall_left, gnt, phase, lat;

  task automatic model_reset();
    idle = 1; send = 0; half = 0; late = 0; pri = 0;
    enc_due = -1; valid_due = -1; err_due = -1; stall_left = 0;
    last_nib = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    req0_valid = 0; req1_valid = 0; req0_data = '0; req1_data = '0;
    enc_valid = 0; enc_code = '0; out_ready = 0;
    model_reset();
    want_reset = 0; force_both = 0;
    repeat (3) @(negedge clk);
    req0_valid = 1; req1_valid = 1; out_ready = 1;
    #1 check_zero("reset");
    req0_valid = 0; req1_valid = 0; out_ready = 0;
    @(negedge clk);
    rst_n = 1'b1;

    for (int c = 0; c < NCYC; c++) begin
      @(negedge clk);
      cyc = c;
      if (c == 1000) want_reset = 1;
      if (want_reset && send && half) begin
        rst_n = 1'b0;
        req0_valid = 1; req1_valid = 1; out_ready = 1;
        #1 check_zero("reset_send_hi");
        model_reset();
        want_reset = 0;
        force_both = 1;
        req0_valid = 0; req1_valid = 0; enc_valid = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
      end

      phase = (c < 12) ? 0 : (c < 600) ? 1 : (c < 800) ? 2 : (c < 900) ? 3 : 4;

      case (phase)
        0: begin
          req0_valid = (c == 0); req0_data = 8'hA5; req1_valid = 0;
        end
        2: begin
          req0_valid = 1; req0_data = 8'h11; req1_valid = 1; req1_data = 8'h22;
        end
        default: begin
          req0_valid = ($urandom_range(0, 2) == 0);
          req1_valid = ($urandom_range(0, 2) == 0);
          req0_data  = 8'($urandom);
          req1_data  = 8'($urandom);
        end
      endcase
      if (force_both) begin
        req0_valid = 1; req1_valid = 1; force_both = 0;
      end

      if (phase == 0)          out_ready = 1;
      else if (stall_left > 0) out_ready = 0;
      else                     out_ready = ($urandom_range(0, 3) != 0);
      if (stall_left > 0) stall_left--;

      enc_valid = (c == valid_due);
      enc_code  = enc_valid ? pend_code : 7'($urandom);
      if (!enc_valid && (idle || send) && phase != 0 && phase != 3 && $urandom_range(0, 7) == 0)
        enc_valid = 1;

      gnt = -1;
      if (idle) begin
        if (req0_valid && req1_valid) gnt = pri;
        else if (req0_valid)          gnt = 0;
        else if (req1_valid)          gnt = 1;
      end
      if (c == enc_due) last_nib = half ? cur_byte[7:4] : cur_byte[3:0];

      #1;
      check("req0_ready", req0_ready, gnt == 0);
      check("req1_ready", req1_ready, gnt == 1);
      check("enc_ena",    enc_ena,    c == enc_due);
      check("enc_data",   enc_data,   last_nib);
      check("err",        err,        c == err_due);
      check("out_valid",  out_valid,  send);
      if (send) begin
        check("out_code", out_code, exp_code);
        check("out_src",  out_src,  cur_src);
        check("out_half", out_half, half);
      end

      if (gnt >= 0) begin
        idle     = 0;
        cur_src  = gnt[0];
        cur_byte = gnt[0] ? req1_data : req0_data;
        half     = 0;
        enc_due  = c + 1;
        pri      = ~gnt[0];
      end
      if (c == enc_due) begin
        if (phase == 0 || phase == 2)  lat = 1;
        else if (phase == 3)           lat = 0;
        else if ($urandom_range(0, 9) < 6) lat = 1;
        else                           lat = $urandom_range(2, T + 1);
        pend_code = ham(enc_data);
        exp_code  = ham(last_nib);
        late      = (lat == 0) || (lat > T);
        valid_due = (lat == 0) ? -1 : c + lat;
        if (late) err_due = c + 1 + T;
      end
      if (c == valid_due && !late) begin
        send = 1;
        if (phase != 0 && $urandom_range(0, 4) == 0) stall_left = 10;
      end else if (send && out_ready) begin
        send = 0;
        if (!half) begin
          half    = 1;
          enc_due = c + 1;
        end else begin
          idle = 1;
        end
      end
      if (c + 1 == err_due) idle = 1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
